// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target with 7-bit address match and 8-bit register pointer interface
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h3F
) (
  input  logic       slowclk,
  input  logic       rstn,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  input  logic [7:0] reg_rdata,
  output logic       reg_wr,
  output logic [7:0] reg_wdata,
  output logic       busy
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] ADDR     = 4'd1;
  localparam logic [3:0] ADDR_ACK = 4'd2;
  localparam logic [3:0] WR_PTR   = 4'd3;
  localparam logic [3:0] WR_ACK   = 4'd4;
  localparam logic [3:0] WR_DATA  = 4'd5;
  localparam logic [3:0] DATA_ACK = 4'd6;
  localparam logic [3:0] RD_DATA  = 4'd7;
  localparam logic [3:0] RD_ACK   = 4'd8;
  localparam logic [3:0] IGNORE   = 4'd9;

  logic [3:0] state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic       rw;
  logic       scl_s1, scl_s2, scl_prev;
  logic       sda_s1, sda_s2, sda_prev;

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s2 & ~scl_prev;
  assign scl_fall  = ~scl_s2 & scl_prev;
  assign start_det = scl_s2 & scl_prev & sda_prev & ~sda_s2;
  assign stop_det  = scl_s2 & scl_prev & ~sda_prev & sda_s2;

  always_ff @(posedge slowclk or negedge rstn) begin
    if (!rstn) begin
      scl_s1    <= 1'b1;
      scl_s2    <= 1'b1;
      scl_prev  <= 1'b1;
      sda_s1    <= 1'b1;
      sda_s2    <= 1'b1;
      sda_prev  <= 1'b1;
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      shreg     <= 8'h00;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wr    <= 1'b0;
      reg_wdata <= 8'h00;
      busy      <= 1'b0;
    end else begin
      scl_s1   <= scl_in;
      scl_s2   <= scl_s1;
      scl_prev <= scl_s2;
      sda_s1   <= sda_in;
      sda_s2   <= sda_s1;
      sda_prev <= sda_s2;
      reg_wr   <= 1'b0;
      // pointer advances the cycle after the strobe so reg_wr sees the old address
      if (reg_wr) reg_addr <= reg_addr + 8'd1;

      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR, WR_PTR, WR_DATA: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda_s2};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (state == ADDR) begin
                if (shreg[7:1] == TARGET_ADDR) begin
                  rw     <= shreg[0];
                  sda_oe <= 1'b1;
                  busy   <= 1'b1;
                  state  <= ADDR_ACK;
                end else begin
                  busy  <= 1'b0;
                  state <= IGNORE;
                end
              end else if (state == WR_PTR) begin
                reg_addr <= shreg;
                sda_oe   <= 1'b1;
                state    <= WR_ACK;
              end else begin
                reg_wdata <= shreg;
                reg_wr    <= 1'b1;
                sda_oe    <= 1'b1;
                state     <= DATA_ACK;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (rw) begin
                shreg   <= reg_rdata;
                sda_oe  <= ~reg_rdata[7];
                bit_cnt <= 4'd1;
                state   <= RD_DATA;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= WR_PTR;
              end
            end
          end
          WR_ACK, DATA_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= RD_ACK;
              end else begin
                sda_oe  <= ~shreg[6];
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          RD_ACK: begin
            // a fall seen here always follows an ACK rise; NACK leaves at the rise
            if (scl_rise) begin
              if (sda_s2) begin
                sda_oe <= 1'b0;
                busy   <= 1'b0;
                state  <= IGNORE;
              end else begin
                reg_addr <= reg_addr + 8'd1;
              end
            end else if (scl_fall) begin
              shreg   <= reg_rdata;
              sda_oe  <= ~reg_rdata[7];
              bit_cnt <= 4'd1;
              state   <= RD_DATA;
            end
          end
          IGNORE: sda_oe <= 1'b0;
          default: begin
            sda_oe <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed bench driving an I2C master model against i2c_target
module tb_i2c_target;

  localparam time Q = 60ns;

  logic       slowclk = 1'b0;
  logic       rstn    = 1'b0;
  logic       scl     = 1'b1;
  logic       sda_m   = 1'b1;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_rdata;
  logic       reg_wr;
  logic [7:0] reg_wdata;
  logic       busy;
  logic       sda_bus;

  int total = 0;
  int bad   = 0;
  int wr_n  = 0;
  int oe_hits = 0;
  logic [7:0] wr_addr_log [16];
  logic [7:0] wr_data_log [16];

  assign sda_bus = sda_m & ~sda_oe;

  always #5ns slowclk = ~slowclk;

  i2c_target #(.TARGET_ADDR(7'h3F)) dut (
    .slowclk  (slowclk),
    .rstn     (rstn),
    .scl_in   (scl),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .reg_addr (reg_addr),
    .reg_rdata(reg_rdata),
    .reg_wr   (reg_wr),
    .reg_wdata(reg_wdata),
    .busy     (busy)
  );

  // fixed register contents; writes are only logged
  always_comb begin
    reg_rdata = 8'h00;
    case (reg_addr)
      8'h10: reg_rdata = 8'h0F;
      8'hFE: reg_rdata = 8'hA5;
      8'hFF: reg_rdata = 8'h3C;
      8'h00: reg_rdata = 8'hC3;
      default: reg_rdata = 8'h00;
    endcase
  end

  always @(posedge slowclk) begin
    if (reg_wr === 1'b1) begin
      if (wr_n < 16) begin
        wr_addr_log[wr_n] = reg_addr;
        wr_data_log[wr_n] = reg_wdata;
      end
      wr_n = wr_n + 1;
    end
    if (sda_oe === 1'b1) oe_hits = oe_hits + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clk_bit(input logic b, output logic bus_v, output logic oe_v);
    sda_m = b;
    #Q; scl = 1'b1;
    #Q; bus_v = sda_bus; oe_v = sda_oe;
    #Q; scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; #Q;
    scl   = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; #Q;
    scl   = 1'b1; #Q;
    sda_m = 1'b1; #Q;
    #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_oe);
    logic bv, ov;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], bv, ov);
    clk_bit(1'b1, bv, ack_oe);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d, output logic ack_oe);
    logic bv, ov;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, bv, ov);
      d[i] = bv;
    end
    clk_bit(mack, bv, ack_oe);
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    int         base;

    #20ns;
    chk("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
    chk("rst_reg_wr", {15'd0, reg_wr}, 16'd0);
    chk("rst_reg_addr", {8'd0, reg_addr}, 16'h00);
    chk("rst_reg_wdata", {8'd0, reg_wdata}, 16'h00);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    rstn = 1'b1;
    #100ns;

    // single write: 0x3F+W, ptr 0x10, data 0xF0
    base = wr_n;
    i2c_start;
    write_byte(8'h7E, a); chk("t1_addr_ack", {15'd0, a}, 16'd1);
    chk("t1_busy", {15'd0, busy}, 16'd1);
    write_byte(8'h10, a); chk("t1_ptr_ack", {15'd0, a}, 16'd1);
    write_byte(8'hF0, a); chk("t1_data_ack", {15'd0, a}, 16'd1);
    i2c_stop;
    chk("t1_wr_count", 16'(wr_n - base), 16'd1);
    chk("t1_wr_addr", {8'd0, wr_addr_log[base]}, 16'h10);
    chk("t1_wr_data", {8'd0, wr_data_log[base]}, 16'hF0);
    chk("t1_busy_stop", {15'd0, busy}, 16'd0);
    chk("t1_ptr_end", {8'd0, reg_addr}, 16'h11);

    // pointer set, repeated START, read one byte with NACK
    i2c_start;
    write_byte(8'h7E, a); chk("t2_addr_ack", {15'd0, a}, 16'd1);
    write_byte(8'h10, a); chk("t2_ptr_ack", {15'd0, a}, 16'd1);
    i2c_start;
    write_byte(8'h7F, a); chk("t2_raddr_ack", {15'd0, a}, 16'd1);
    read_byte(1'b1, d, a);
    chk("t2_rdata", {8'd0, d}, 16'h0F);
    chk("t2_nack_released", {15'd0, a}, 16'd0);
    chk("t2_busy_nack", {15'd0, busy}, 16'd0);
    i2c_stop;
    chk("t2_busy_stop", {15'd0, busy}, 16'd0);

    // foreign address 0x3E: target stays off the bus
    base = wr_n;
    oe_hits = 0;
    i2c_start;
    write_byte(8'h7C, a); chk("t3_addr_nack", {15'd0, a}, 16'd0);
    chk("t3_busy", {15'd0, busy}, 16'd0);
    write_byte(8'h20, a); chk("t3_b1_nack", {15'd0, a}, 16'd0);
    write_byte(8'h55, a); chk("t3_b2_nack", {15'd0, a}, 16'd0);
    i2c_stop;
    chk("t3_wr_count", 16'(wr_n - base), 16'd0);
    chk("t3_oe_hits", 16'(oe_hits), 16'd0);

    // burst write wrapping the pointer
    base = wr_n;
    i2c_start;
    write_byte(8'h7E, a);
    write_byte(8'hFF, a);
    write_byte(8'hAA, a); chk("t4_d1_ack", {15'd0, a}, 16'd1);
    write_byte(8'h55, a); chk("t4_d2_ack", {15'd0, a}, 16'd1);
    i2c_stop;
    chk("t4_wr_count", 16'(wr_n - base), 16'd2);
    chk("t4_wr0_addr", {8'd0, wr_addr_log[base]}, 16'hFF);
    chk("t4_wr0_data", {8'd0, wr_data_log[base]}, 16'hAA);
    chk("t4_wr1_addr", {8'd0, wr_addr_log[base+1]}, 16'h00);
    chk("t4_wr1_data", {8'd0, wr_data_log[base+1]}, 16'h55);
    chk("t4_ptr_end", {8'd0, reg_addr}, 16'h01);

    // burst read from 0xFE with two ACKs then NACK
    i2c_start;
    write_byte(8'h7E, a);
    write_byte(8'hFE, a);
    i2c_start;
    write_byte(8'h7F, a);
    read_byte(1'b0, d, a); chk("t5_rd0", {8'd0, d}, 16'hA5);
    chk("t5_rd0_ack_released", {15'd0, a}, 16'd0);
    read_byte(1'b0, d, a); chk("t5_rd1", {8'd0, d}, 16'h3C);
    read_byte(1'b1, d, a); chk("t5_rd2", {8'd0, d}, 16'hC3);
    chk("t5_busy", {15'd0, busy}, 16'd0);
    i2c_stop;
    chk("t5_ptr_end", {8'd0, reg_addr}, 16'h00);

    // STOP part-way through a data byte
    base = wr_n;
    i2c_start;
    write_byte(8'h7E, a);
    write_byte(8'h20, a);
    for (int i = 0; i < 4; i++) begin
      logic bv, ov;
      clk_bit(1'b1, bv, ov);
    end
    i2c_stop;
    chk("t6_wr_count", 16'(wr_n - base), 16'd0);
    chk("t6_busy", {15'd0, busy}, 16'd0);
    chk("t6_ptr", {8'd0, reg_addr}, 16'h20);

    // async reset while driving read data (reg 0x20 = 0x00, MSB drives low)
    i2c_start;
    write_byte(8'h7F, a); chk("t7_addr_ack", {15'd0, a}, 16'd1);
    chk("t7_driving", {15'd0, sda_oe}, 16'd1);
    #3ns;
    rstn = 1'b0;
    #1ns;
    chk("t7_sda_oe", {15'd0, sda_oe}, 16'd0);
    chk("t7_busy", {15'd0, busy}, 16'd0);
    chk("t7_reg_addr", {8'd0, reg_addr}, 16'h00);
    chk("t7_reg_wr", {15'd0, reg_wr}, 16'd0);
    chk("t7_reg_wdata", {8'd0, reg_wdata}, 16'h00);
    sda_m = 1'b1;
    scl   = 1'b1;
    #50ns;
    rstn = 1'b1;
    #100ns;
    chk("t7_idle_oe", {15'd0, sda_oe}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
